// File: rtl/wb_arb2_sgdma_if.sv
// One Wishbone point-to-point link: initiator drives request fields, target drives responses.
interface wb_arb2_sgdma_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  localparam int NUMBYTE = DWIDTH / 8;

  logic [AWIDTH-1:0]  adr;
  logic [DWIDTH-1:0]  dat_w;
  logic [DWIDTH-1:0]  dat_r;
  logic               cyc;
  logic               stb;
  logic               we;
  logic [NUMBYTE-1:0] sel;
  logic [2:0]         cti;
  logic               ack;
  logic               err;
  logic               rty;
  logic               eod;

  modport master (
    output adr, dat_w, cyc, stb, sel, cti, we,
    input  dat_r, ack, err, rty, eod
  );

  modport slave (
    input  adr, dat_w, cyc, stb, sel, cti, we,
    output dat_r, ack, err, rty, eod
  );
endinterface

// File: rtl/wb_arb2_sgdma.sv
// Two-master round-robin Wishbone arbiter for the SGDMA read (m0) and write (m1) channels,
// with a response watchdog that turns a silent slave into a master-side err.
module wb_arb2_sgdma #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_arb2_sgdma_if.slave        m0,
  wb_arb2_sgdma_if.slave        m1,
  wb_arb2_sgdma_if.master       s,
  output logic [1:0]            gnt,
  output logic                  timeout_evt
);
  localparam int NUMBYTE = DWIDTH / 8;
  localparam int WCW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int WMAX_I  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [WCW-1:0] WMAX = WCW'(WMAX_I);

  // state | meaning
  // IDLE  | no owner; arbitrate among raised cyc lines
  // G0    | m0 owns the slave until m0.cyc drops
  // G1    | m1 owns the slave until m1.cyc drops
  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  state_t              state, state_nxt;
  logic                rr_m1;
  logic [WCW-1:0]      wcnt, wcnt_nxt;
  logic                gstb, resp, wd_fire;
  logic [AWIDTH-1:0]   adr_mux;
  logic [NUMBYTE-1:0]  sel_mux;

  assign s.adr       = adr_mux;
  assign s.sel       = sel_mux;
  assign timeout_evt = wd_fire;

  always_comb begin
    resp = s.ack | s.err | s.rty;
    gstb = 1'b0;
    if (state == G0)      gstb = m0.cyc & m0.stb;
    else if (state == G1) gstb = m1.cyc & m1.stb;
    wd_fire = (TIMEOUT > 0) && gstb && !resp && (wcnt == WMAX);
  end

  always_comb begin
    wcnt_nxt = '0;
    if ((TIMEOUT > 0) && gstb && !resp && !wd_fire)
      wcnt_nxt = (wcnt == WMAX) ? wcnt : wcnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    gnt       = 2'b00;
    adr_mux   = '0;
    sel_mux   = '0;
    s.dat_w   = '0;
    s.cti     = 3'd0;
    s.we      = 1'b0;
    s.cyc     = 1'b0;
    s.stb     = 1'b0;
    m0.dat_r  = '0;
    m0.ack    = 1'b0;
    m0.err    = 1'b0;
    m0.rty    = 1'b0;
    m0.eod    = 1'b0;
    m1.dat_r  = '0;
    m1.ack    = 1'b0;
    m1.err    = 1'b0;
    m1.rty    = 1'b0;
    m1.eod    = 1'b0;
    case (state)
      IDLE: begin
        if (m0.cyc && (!m1.cyc || !rr_m1)) state_nxt = G0;
        else if (m1.cyc)                   state_nxt = G1;
      end
      G0: begin
        gnt      = 2'b01;
        adr_mux  = m0.adr;
        sel_mux  = m0.sel;
        s.dat_w  = m0.dat_w;
        s.cti    = m0.cti;
        s.we     = m0.we;
        s.cyc    = m0.cyc;
        s.stb    = gstb & ~wd_fire;
        m0.dat_r = s.dat_r;
        // Responses are gated by cyc so a late ack after the master gives up is dropped.
        m0.ack   = m0.cyc & s.ack;
        m0.err   = (m0.cyc & s.err) | wd_fire;
        m0.rty   = m0.cyc & s.rty;
        m0.eod   = m0.cyc & s.eod;
        if (!m0.cyc) state_nxt = IDLE;
      end
      G1: begin
        gnt      = 2'b10;
        adr_mux  = m1.adr;
        sel_mux  = m1.sel;
        s.dat_w  = m1.dat_w;
        s.cti    = m1.cti;
        s.we     = m1.we;
        s.cyc    = m1.cyc;
        s.stb    = gstb & ~wd_fire;
        m1.dat_r = s.dat_r;
        m1.ack   = m1.cyc & s.ack;
        m1.err   = (m1.cyc & s.err) | wd_fire;
        m1.rty   = m1.cyc & s.rty;
        m1.eod   = m1.cyc & s.eod;
        if (!m1.cyc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_m1 <= 1'b0;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      // The releasing master loses priority for the next contested arbitration.
      if (state == G0 && !m0.cyc)      rr_m1 <= 1'b1;
      else if (state == G1 && !m1.cyc) rr_m1 <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_arb2_sgdma.sv
// Self-checking bench for wb_arb2_sgdma: directed scenarios plus a randomized run,
// all compared against a cycle-level model of the arbitration and watchdog rules.
module tb_wb_arb2_sgdma;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gnt;
  logic       timeout_evt;
  int         errors = 0;
  int         checks = 0;

  int m_owner;
  int m_fav;
  int m_silent;

  wb_arb2_sgdma_if #(.DWIDTH(32), .AWIDTH(32)) m0_bus ();
  wb_arb2_sgdma_if #(.DWIDTH(32), .AWIDTH(32)) m1_bus ();
  wb_arb2_sgdma_if #(.DWIDTH(32), .AWIDTH(32)) s_bus ();

  wb_arb2_sgdma #(.DWIDTH(32), .AWIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .m0          (m0_bus),
    .m1          (m1_bus),
    .s           (s_bus),
    .gnt         (gnt),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

  function automatic logic [148:0] dut_obs();
    return {gnt, timeout_evt, s_bus.cyc, s_bus.stb, s_bus.we, s_bus.cti, s_bus.sel,
            s_bus.adr, s_bus.dat_w, m0_bus.ack, m0_bus.err, m0_bus.rty, m0_bus.eod,
            m1_bus.ack, m1_bus.err, m1_bus.rty, m1_bus.eod, m0_bus.dat_r, m1_bus.dat_r};
  endfunction

  // Expected outputs this cycle, from who owns the bus and how long the slave has been silent.
  function automatic logic [148:0] model_obs();
    int own;
    logic cy, gcs, resp, fire, sc, ss, swe;
    logic [1:0] g;
    logic [2:0] scti;
    logic [3:0] ssel, r0, r1, rsp;
    logic [31:0] sadr, sdat, d0, d1;
    own = rst ? -1 : m_owner;
    g = '0; sc = 0; ss = 0; swe = 0; scti = '0; ssel = '0; sadr = '0; sdat = '0;
    d0 = '0; d1 = '0; r0 = '0; r1 = '0; rsp = '0; fire = 0; cy = 0; gcs = 0;
    resp = s_bus.ack | s_bus.err | s_bus.rty;
    if (own == 0) begin
      g = 2'b01; cy = m0_bus.cyc; gcs = cy & m0_bus.stb; swe = m0_bus.we;
      scti = m0_bus.cti; ssel = m0_bus.sel; sadr = m0_bus.adr; sdat = m0_bus.dat_w;
    end else if (own == 1) begin
      g = 2'b10; cy = m1_bus.cyc; gcs = cy & m1_bus.stb; swe = m1_bus.we;
      scti = m1_bus.cti; ssel = m1_bus.sel; sadr = m1_bus.adr; sdat = m1_bus.dat_w;
    end
    if (own >= 0) begin
      fire = gcs && !resp && (m_silent + 1 == TIMEOUT);
      sc = cy;
      ss = gcs && !fire;
      rsp = {cy & s_bus.ack, (cy & s_bus.err) | fire, cy & s_bus.rty, cy & s_bus.eod};
      if (own == 0) begin r0 = rsp; d0 = s_bus.dat_r; end
      else          begin r1 = rsp; d1 = s_bus.dat_r; end
    end
    return {g, fire, sc, ss, swe, scti, ssel, sadr, sdat, r0, r1, d0, d1};
  endfunction

  task automatic model_update();
    logic [148:0] o;
    logic fire, cy, gcs, resp;
    o = model_obs();
    fire = o[146];
    if (rst) begin
      m_owner = -1; m_fav = 0; m_silent = 0;
    end else if (m_owner < 0) begin
      m_silent = 0;
      if (m0_bus.cyc && m1_bus.cyc) m_owner = m_fav;
      else if (m0_bus.cyc)          m_owner = 0;
      else if (m1_bus.cyc)          m_owner = 1;
    end else begin
      cy   = (m_owner == 0) ? m0_bus.cyc : m1_bus.cyc;
      gcs  = cy & ((m_owner == 0) ? m0_bus.stb : m1_bus.stb);
      resp = s_bus.ack | s_bus.err | s_bus.rty;
      m_silent = (gcs && !resp && !fire) ? m_silent + 1 : 0;
      if (!cy) begin
        m_fav = 1 - m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_all();
    m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.we = 0; m0_bus.cti = '0; m0_bus.sel = '0;
    m0_bus.adr = '0; m0_bus.dat_w = '0;
    m1_bus.cyc = 0; m1_bus.stb = 0; m1_bus.we = 0; m1_bus.cti = '0; m1_bus.sel = '0;
    m1_bus.adr = '0; m1_bus.dat_w = '0;
    s_bus.ack = 0; s_bus.err = 0; s_bus.rty = 0; s_bus.eod = 0; s_bus.dat_r = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_all();
    tick(); tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    checks++; if (s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0) begin errors++; $display("FAIL reset_s_cyc_stb got=%b%b exp=00", s_bus.cyc, s_bus.stb); end
    checks++; if (timeout_evt !== 1'b0) begin errors++; $display("FAIL reset_timeout_evt got=%b exp=0", timeout_evt); end
    checks++; if (dut_obs() !== model_obs()) begin errors++; $display("FAIL reset_all got=%h exp=%h", dut_obs(), model_obs()); end
    tick();
    rst = 0;
  endtask

  task automatic test_single_write();
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.we = 1; m0_bus.adr = 32'h10;
    m0_bus.dat_w = 32'hA5A5A5A5; m0_bus.sel = 4'hF; m0_bus.cti = 3'd0;
    @(negedge clk);
    checks++; if (gnt !== 2'b00 || s_bus.cyc !== 1'b0) begin errors++; $display("FAIL single_arb_cycle got=%b/%b exp=00/0", gnt, s_bus.cyc); end
    tick();
    s_bus.ack = 1;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got=%b exp=01", gnt); end
    checks++; if (s_bus.we !== 1'b1 || s_bus.adr !== 32'h10) begin errors++; $display("FAIL single_we_adr got=%b/%h exp=1/10", s_bus.we, s_bus.adr); end
    checks++; if (s_bus.dat_w !== 32'hA5A5A5A5 || s_bus.sel !== 4'hF) begin errors++; $display("FAIL single_dat_sel got=%h/%h exp=a5a5a5a5/f", s_bus.dat_w, s_bus.sel); end
    checks++; if (m0_bus.ack !== 1'b1 || m1_bus.ack !== 1'b0) begin errors++; $display("FAIL single_acks got=%b%b exp=10", m0_bus.ack, m1_bus.ack); end
    tick();
    m0_bus.cyc = 0; m0_bus.stb = 0; s_bus.ack = 0;
    @(negedge clk);
    checks++; if (s_bus.cyc !== 1'b0) begin errors++; $display("FAIL single_cyc_drop got=%b exp=0", s_bus.cyc); end
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL single_release got=%b exp=00", gnt); end
  endtask

  task automatic test_both_at_reset();
    rst = 1;
    idle_all();
    m0_bus.cyc = 1; m0_bus.stb = 1; m1_bus.cyc = 1; m1_bus.stb = 1;
    tick();
    rst = 0;
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL both_idle got=%b exp=00", gnt); end
    tick();
    s_bus.ack = 1;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL both_first_m0 got=%b exp=01", gnt); end
    checks++; if (m0_bus.ack !== 1'b1 || m1_bus.ack !== 1'b0) begin errors++; $display("FAIL both_acks got=%b%b exp=10", m0_bus.ack, m1_bus.ack); end
    tick();
    m0_bus.cyc = 0; m0_bus.stb = 0; s_bus.ack = 0;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b00 || s_bus.cyc !== 1'b0) begin errors++; $display("FAIL both_gap got=%b/%b exp=00/0", gnt, s_bus.cyc); end
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL both_then_m1 got=%b exp=10", gnt); end
    tick();
    m1_bus.cyc = 0; m1_bus.stb = 0;
    tick();
    m0_bus.cyc = 1; m0_bus.stb = 1;
    tick();
    m0_bus.cyc = 0; m0_bus.stb = 0;
    tick();
    m0_bus.cyc = 1; m0_bus.stb = 1; m1_bus.cyc = 1; m1_bus.stb = 1;
    @(negedge clk);
    checks++; if (dut_obs() !== model_obs()) begin errors++; $display("FAIL both_rr_idle got=%h exp=%h", dut_obs(), model_obs()); end
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL both_rr_m1 got=%b exp=10", gnt); end
    tick();
    idle_all();
    tick(); tick();
  endtask

  task automatic test_burst();
    logic [31:0] rd;
    m1_bus.cyc = 1; m1_bus.stb = 1; m1_bus.we = 0; m1_bus.cti = 3'd2; m1_bus.adr = 32'h100;
    m1_bus.sel = 4'hF;
    @(negedge clk);
    tick();
    m0_bus.cyc = 1; m0_bus.stb = 1;
    for (int b = 0; b < 4; b++) begin
      m1_bus.cti = (b == 3) ? 3'd7 : 3'd2;
      m1_bus.adr = 32'h100 + 32'(4 * b);
      rd = $urandom;
      s_bus.dat_r = rd; s_bus.ack = 1;
      @(negedge clk);
      checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL burst_gnt[%0d] got=%b exp=10", b, gnt); end
      checks++; if (m1_bus.ack !== 1'b1 || m1_bus.dat_r !== rd) begin errors++; $display("FAIL burst_m1_rsp[%0d] got=%b/%h exp=1/%h", b, m1_bus.ack, m1_bus.dat_r, rd); end
      checks++; if (m0_bus.ack !== 1'b0 || m0_bus.dat_r !== 32'h0) begin errors++; $display("FAIL burst_m0_quiet[%0d] got=%b/%h exp=0/0", b, m0_bus.ack, m0_bus.dat_r); end
      checks++; if (s_bus.cti !== ((b == 3) ? 3'd7 : 3'd2)) begin errors++; $display("FAIL burst_cti[%0d] got=%0d", b, s_bus.cti); end
      checks++; if (dut_obs() !== model_obs()) begin errors++; $display("FAIL burst_all[%0d] got=%h exp=%h", b, dut_obs(), model_obs()); end
      tick();
    end
    m1_bus.cyc = 0; m1_bus.stb = 0; s_bus.ack = 0;
    @(negedge clk);
    checks++; if (gnt !== 2'b10 || s_bus.cyc !== 1'b0) begin errors++; $display("FAIL burst_drop got=%b/%b exp=10/0", gnt, s_bus.cyc); end
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL burst_gap got=%b exp=00", gnt); end
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL burst_m0_next got=%b exp=01", gnt); end
    tick();
    idle_all();
    tick(); tick();
  endtask

  task automatic test_retry();
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.we = 1; m0_bus.adr = $urandom; m0_bus.dat_w = $urandom;
    m0_bus.sel = 4'hF;
    @(negedge clk);
    tick();
    for (int k = 0; k < 3; k++) begin
      s_bus.rty = (k < 2); s_bus.ack = (k == 2);
      @(negedge clk);
      checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL retry_gnt[%0d] got=%b exp=01", k, gnt); end
      checks++; if (m0_bus.rty !== (k < 2) || m0_bus.ack !== (k == 2)) begin errors++; $display("FAIL retry_rsp[%0d] got=rty%b ack%b", k, m0_bus.rty, m0_bus.ack); end
      tick();
    end
    idle_all();
    tick(); tick();
  endtask

  task automatic test_timeout();
    logic f;
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.adr = 32'h40;
    @(negedge clk);
    tick();
    for (int k = 0; k < 18; k++) begin
      f = (k == 7) || (k == 15);
      @(negedge clk);
      checks++; if (timeout_evt !== f) begin errors++; $display("FAIL wd_evt[%0d] got=%b exp=%b", k, timeout_evt, f); end
      checks++; if (m0_bus.err !== f) begin errors++; $display("FAIL wd_err[%0d] got=%b exp=%b", k, m0_bus.err, f); end
      checks++; if (s_bus.stb !== !f) begin errors++; $display("FAIL wd_stb[%0d] got=%b exp=%b", k, s_bus.stb, !f); end
      checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL wd_gnt[%0d] got=%b exp=01", k, gnt); end
      tick();
    end
    idle_all();
    tick(); tick();
  endtask

  task automatic test_reset_mid_burst();
    m1_bus.cyc = 1; m1_bus.stb = 1; m1_bus.cti = 3'd2; m1_bus.adr = 32'h200;
    @(negedge clk);
    tick();
    for (int b = 0; b < 3; b++) begin
      s_bus.ack = 1; s_bus.dat_r = $urandom;
      @(negedge clk);
      checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rstmid_gnt[%0d] got=%b exp=10", b, gnt); end
      if (b == 2) begin
        #1 rst = 1;
        #1;
        checks++; if (gnt !== 2'b00 || s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0) begin errors++; $display("FAIL rstmid_idle got=%b/%b/%b exp=00/0/0", gnt, s_bus.cyc, s_bus.stb); end
        checks++; if (m1_bus.ack !== 1'b0 || m1_bus.dat_r !== 32'h0) begin errors++; $display("FAIL rstmid_rsp got=%b/%h exp=0/0", m1_bus.ack, m1_bus.dat_r); end
        checks++; if (dut_obs() !== model_obs()) begin errors++; $display("FAIL rstmid_all got=%h exp=%h", dut_obs(), model_obs()); end
      end
      tick();
    end
    rst = 0;
    idle_all();
    m0_bus.cyc = 1; m0_bus.stb = 1;
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rstmid_after_idle got=%b exp=00", gnt); end
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rstmid_after_m0 got=%b exp=01", gnt); end
    tick();
    idle_all();
    tick(); tick();
  endtask

  task automatic test_random();
    logic quiet;
    for (int i = 0; i < 480; i++) begin
      quiet = ((i / 40) % 3) == 2;
      rst = ($urandom_range(0, 127) == 0);
      m0_bus.cyc = m0_bus.cyc ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
      m1_bus.cyc = m1_bus.cyc ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
      m0_bus.stb = m0_bus.cyc & (quiet | ($urandom_range(0, 3) != 0));
      m1_bus.stb = m1_bus.cyc & (quiet | ($urandom_range(0, 3) != 0));
      m0_bus.adr = $urandom; m0_bus.dat_w = $urandom; m0_bus.sel = 4'($urandom_range(0, 15));
      m1_bus.adr = $urandom; m1_bus.dat_w = $urandom; m1_bus.sel = 4'($urandom_range(0, 15));
      m0_bus.cti = 3'($urandom_range(0, 7)); m0_bus.we = 1'($urandom_range(0, 1));
      m1_bus.cti = 3'($urandom_range(0, 7)); m1_bus.we = 1'($urandom_range(0, 1));
      s_bus.ack = !quiet && ($urandom_range(0, 2) == 0);
      s_bus.err = !quiet && ($urandom_range(0, 15) == 0);
      s_bus.rty = !quiet && ($urandom_range(0, 15) == 0);
      s_bus.eod = ($urandom_range(0, 7) == 0);
      s_bus.dat_r = $urandom;
      @(negedge clk);
      checks++; if (dut_obs() !== model_obs()) begin errors++; $display("FAIL rand[%0d] got=%h exp=%h", i, dut_obs(), model_obs()); end
      tick();
    end
    rst = 0;
    idle_all();
    tick(); tick();
  endtask

  initial begin
    m_owner = -1; m_fav = 0; m_silent = 0;
    test_reset();
    test_single_write();
    test_both_at_reset();
    test_burst();
    test_retry();
    test_timeout();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
